// File: rtl/note_pkg.sv
// Shared note-player definitions: receiver FSM states, note codes and the
// ASCII-to-note decoder used by the UART front end, sequencer and display.
package note_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } rx_state_e;

  localparam logic [2:0] NOTE_NONE = 3'd0;
  localparam logic [2:0] NOTE_C    = 3'd1;
  localparam logic [2:0] NOTE_D    = 3'd2;
  localparam logic [2:0] NOTE_E    = 3'd3;
  localparam logic [2:0] NOTE_F    = 3'd4;
  localparam logic [2:0] NOTE_G    = 3'd5;
  localparam logic [2:0] NOTE_A    = 3'd6;
  localparam logic [2:0] NOTE_B    = 3'd7;

  // Rounded clocks-per-oversample-tick divider.
  function automatic int calc_div(input int clk_hz, input int baud, input int ovs);
    return (clk_hz + (baud * ovs) / 2) / (baud * ovs);
  endfunction

  // Clearing bit 5 folds 'a'..'z' onto 'A'..'Z'; no other byte lands on a letter.
  function automatic logic [2:0] ascii_to_note(input logic [7:0] c);
    logic [7:0] u;
    u = c & 8'hDF;
    case (u)
      8'h43:   return NOTE_C;
      8'h44:   return NOTE_D;
      8'h45:   return NOTE_E;
      8'h46:   return NOTE_F;
      8'h47:   return NOTE_G;
      8'h41:   return NOTE_A;
      8'h42:   return NOTE_B;
      default: return NOTE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/note_uart_rx_if.sv
// Byte/note handshake between the UART receiver and the note consumer.
interface note_uart_rx_if;
  logic       rd_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] note_code;
  logic       frame_err;
  logic       overrun;

  modport master (
    input  rd_en,
    output rx_data, rx_valid, note_code, frame_err, overrun
  );

  modport slave (
    output rd_en,
    input  rx_data, rx_valid, note_code, frame_err, overrun
  );
endinterface

// File: rtl/rx_fifo.sv
// First-word-fall-through byte FIFO; pointers carry one wrap bit so full and
// empty are distinguishable without a separate counter.
module rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop_req,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wptr, rptr;
  logic [W-1:0] mem [DEPTH];
  logic         pop, wr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = pop_req && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign wr    = push && (!full || pop);
  assign head  = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/note_uart_rx.sv
// 8N1 UART receiver with 16x oversampling, a small FWFT byte FIFO and a
// combinational note decode of the FIFO head.
module note_uart_rx import note_pkg::*; #(
  parameter int CLK_HZ = 25_000_000,
  parameter int BAUD   = 9600,
  parameter int OVS    = 16,
  parameter int DEPTH  = 4
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           mRxD,
  note_uart_rx_if.master bus
);
  localparam int DIV = calc_div(CLK_HZ, BAUD, OVS);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW  = $clog2(OVS);
  localparam logic [TW-1:0] MID  = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVS - 1);

  logic          rx_s1, rxs, rxs_q;
  logic [CW-1:0] cnt;
  logic          tick, div_clr;
  rx_state_e     state, state_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [2:0]    bidx, bidx_n;
  logic [7:0]    shreg, shreg_n;
  logic          push, ferr, ferr_q, ovr_q;
  logic          fifo_empty, fifo_full, pop;
  logic [7:0]    head;

  // Sync flops idle high so a line held low across reset is not a start edge
  // until it has been seen high again.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_q <= 1'b1;
    end else begin
      rx_s1 <= mRxD;
      rxs   <= rx_s1;
      rxs_q <= rxs;
    end
  end

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)               cnt <= '0;
    else if (div_clr||tick) cnt <= '0;
    else                    cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state  <= S_IDLE;
      tcnt   <= '0;
      bidx   <= '0;
      shreg  <= '0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      state  <= state_n;
      tcnt   <= tcnt_n;
      bidx   <= bidx_n;
      shreg  <= shreg_n;
      ferr_q <= ferr;
      ovr_q  <= push && fifo_full && !pop;
    end
  end

  always_comb begin
    state_n = state;
    tcnt_n  = tcnt;
    bidx_n  = bidx;
    shreg_n = shreg;
    div_clr = 1'b0;
    push    = 1'b0;
    ferr    = 1'b0;
    case (state)
      S_IDLE: begin
        if (rxs_q && !rxs) begin
          state_n = S_START;
          tcnt_n  = '0;
          div_clr = 1'b1;
        end
      end
      S_START: begin
        if (tick) begin
          if (tcnt == MID) begin
            tcnt_n = '0;
            bidx_n = '0;
            state_n = rxs ? S_IDLE : S_DATA;
          end else begin
            tcnt_n = tcnt + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (tcnt == LAST) begin
            tcnt_n  = '0;
            shreg_n = {rxs, shreg[7:1]};
            if (bidx == 3'd7) state_n = S_STOP;
            else              bidx_n  = bidx + 3'd1;
          end else begin
            tcnt_n = tcnt + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (tcnt == LAST) begin
            tcnt_n = '0;
            if (rxs) begin
              push    = 1'b1;
              state_n = S_IDLE;
            end else begin
              ferr    = 1'b1;
              state_n = S_WAIT_HIGH;
            end
          end else begin
            tcnt_n = tcnt + 1'b1;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (rxs) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign pop = bus.rd_en && !fifo_empty;

  rx_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clk     (clk),
    .clr     (clr),
    .push    (push),
    .din     (shreg),
    .pop_req (bus.rd_en),
    .head    (head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign bus.rx_data   = head;
  assign bus.rx_valid  = !fifo_empty;
  assign bus.note_code = ascii_to_note(head);
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_note_uart_rx.sv
// Self-checking bench for note_uart_rx: table of clean frames plus hand-written
// false-start, framing-error, overrun, full-FIFO push/pop and mid-frame reset cases.
module tb_note_uart_rx;
  // 750 kHz / (9600*16) = 4.88 -> divider 5 -> 80 clocks per bit.
  localparam int CLK_HZ = 750_000;
  localparam int BAUD   = 9600;
  localparam int OVS    = 16;
  localparam int BIT    = 80;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic mRxD = 1'b1;
  always #5 clk = ~clk;

  note_uart_rx_if bus();

  note_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVS(OVS), .DEPTH(4)) dut (
    .clk  (clk),
    .clr  (clr),
    .mRxD (mRxD),
    .bus  (bus)
  );

  typedef struct {
    logic [7:0] d;
    int         bc;
    logic [2:0] note;
  } vec_t;

  int         vecs = 0;
  int         miscmp = 0;
  int         ferr_n = 0;
  int         ovr_n = 0;
  logic [7:0] exp_q [$];

  always @(negedge clk) begin
    if (bus.frame_err) ferr_n++;
    if (bus.overrun)   ovr_n++;
  end

  function automatic logic [2:0] ref_note(input logic [7:0] c);
    string s;
    s = "CDEFGAB";
    for (int i = 0; i < 7; i++)
      if (c == s[i] || c == (s[i] + 8'd32)) return 3'(i + 1);
    return 3'd0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stopv, input int bc, input int hold_lo);
    mRxD = 1'b0;
    idle(bc);
    for (int i = 0; i < 8; i++) begin
      mRxD = b[i];
      idle(bc);
    end
    mRxD = stopv;
    idle(bc);
    if (hold_lo > 0) begin
      mRxD = 1'b0;
      idle(hold_lo);
    end
    mRxD = 1'b1;
  endtask

  task automatic pop_chk(input string nm);
    logic [7:0] e;
    int n;
    n = 0;
    while (!bus.rx_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " valid"}, 32'(bus.rx_valid), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    chk({nm, " data"}, 32'(bus.rx_data), 32'(e));
    chk({nm, " note"}, 32'(bus.note_code), 32'(ref_note(e)));
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic chk_empty(input string nm);
    chk({nm, " valid"}, 32'(bus.rx_valid), 32'd0);
    chk({nm, " data"},  32'(bus.rx_data),  32'd0);
    chk({nm, " note"},  32'(bus.note_code), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [8];
    int   f0, o0;
    tbl[0] = '{8'h41, BIT,     3'd6};
    tbl[1] = '{8'h63, BIT,     3'd1};
    tbl[2] = '{8'h47, BIT - 1, 3'd5};
    tbl[3] = '{8'h62, BIT + 1, 3'd7};
    tbl[4] = '{8'h5A, BIT,     3'd0};
    tbl[5] = '{8'h00, BIT,     3'd0};
    tbl[6] = '{8'hC3, BIT,     3'd0};
    tbl[7] = '{8'h65, BIT + 1, 3'd3};

    bus.rd_en = 1'b0;
    idle(4);
    chk_empty("reset");
    chk("reset frame_err", 32'(bus.frame_err), 32'd0);
    chk("reset overrun",   32'(bus.overrun),   32'd0);
    clr = 1'b1;
    idle(2 * BIT);

    // 'A' with latency window: stop sample lands 763 clocks after the start edge.
    exp_q.push_back(8'h41);
    fork
      send_byte(8'h41, 1'b1, BIT, 0);
      begin
        idle(755);
        chk("A not early", 32'(bus.rx_valid), 32'd0);
        idle(15);
        chk("A valid after stop", 32'(bus.rx_valid), 32'd1);
        chk("A note", 32'(bus.note_code), 32'd6);
      end
    join
    pop_chk("A");
    chk_empty("A popped");

    foreach (tbl[i]) begin
      exp_q.push_back(tbl[i].d);
      send_byte(tbl[i].d, 1'b1, tbl[i].bc, 0);
      idle(BIT);
      chk($sformatf("tbl%0d note", i), 32'(bus.note_code), 32'(tbl[i].note));
      pop_chk($sformatf("tbl%0d", i));
      chk_empty($sformatf("tbl%0d popped", i));
    end

    // False start: 3 ticks low.
    f0 = ferr_n;
    mRxD = 1'b0;
    idle(15);
    mRxD = 1'b1;
    idle(12 * BIT);
    chk("false start valid", 32'(bus.rx_valid), 32'd0);
    chk("false start ferr", 32'(ferr_n), 32'(f0));

    // Stop bit forced low, line held low for two more bits.
    f0 = ferr_n;
    send_byte(8'h63, 1'b0, BIT, 2 * BIT);
    idle(BIT);
    chk("frame err count", 32'(ferr_n), 32'(f0 + 1));
    chk("frame err valid", 32'(bus.rx_valid), 32'd0);
    exp_q.push_back(8'h44);
    send_byte(8'h44, 1'b1, BIT, 0);
    idle(BIT);
    pop_chk("after ferr D");

    // Five back-to-back bytes into a 4-deep FIFO.
    o0 = ovr_n;
    f0 = ferr_n;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(8'(8'h43 + i));
      send_byte(8'(8'h43 + i), 1'b1, BIT, 0);
    end
    idle(BIT);
    chk("overrun count", 32'(ovr_n), 32'(o0 + 1));
    chk("overrun no ferr", 32'(ferr_n), 32'(f0));
    for (int i = 0; i < 4; i++) pop_chk($sformatf("ovr pop%0d", i));
    chk("ovr drained", 32'(bus.rx_valid), 32'd0);

    // Full FIFO; pop exactly in the cycle the next byte is pushed.
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'(8'h46 + i));
      send_byte(8'(8'h46 + i), 1'b1, BIT, 0);
    end
    idle(BIT);
    o0 = ovr_n;
    exp_q.push_back(8'h42);
    fork
      send_byte(8'h42, 1'b1, BIT, 0);
      begin
        idle(762);
        chk("simul head", 32'(bus.rx_data), 32'(exp_q[0]));
        bus.rd_en = 1'b1;
        void'(exp_q.pop_front());
        idle(1);
        bus.rd_en = 1'b0;
      end
    join
    idle(BIT);
    chk("simul no overrun", 32'(ovr_n), 32'(o0));
    for (int i = 0; i < 4; i++) pop_chk($sformatf("simul pop%0d", i));
    chk("simul drained", 32'(bus.rx_valid), 32'd0);

    // Reset during data bit 3 with a byte already buffered.
    exp_q.push_back(8'h41);
    send_byte(8'h41, 1'b1, BIT, 0);
    idle(BIT);
    chk("pre-reset valid", 32'(bus.rx_valid), 32'd1);
    fork
      send_byte(8'h45, 1'b1, BIT, 0);
      begin
        idle(4 * BIT + 40);
        clr = 1'b0;
        #1;
        chk_empty("midreset");
        chk("midreset ferr", 32'(bus.frame_err), 32'd0);
        chk("midreset ovr",  32'(bus.overrun),   32'd0);
      end
    join
    exp_q.delete();
    idle(2);
    clr = 1'b1;
    idle(2 * BIT);
    chk("post-reset idle", 32'(bus.rx_valid), 32'd0);
    f0 = ferr_n;
    exp_q.push_back(8'h45);
    send_byte(8'h45, 1'b1, BIT, 0);
    idle(BIT);
    chk("post-reset note", 32'(bus.note_code), 32'd3);
    pop_chk("post-reset E");
    chk("post-reset ferr", 32'(ferr_n), 32'(f0));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule

// File: doc/note_uart_rx.md
# note_uart_rx

Serial front end of the note player. It receives 8N1 UART bytes on `mRxD` using 16x oversampling and buffers them in a small first-word-fall-through FIFO. It also decodes the byte at the FIFO head into a 3-bit note code for the note sequencer, which drives `notaSalida`, the audio pin on `JA` and the display paths. It sits between the board pin `mRxD` and the note/command consumer inside `TopBlock`.

## Interface
Parameters:
- `CLK_HZ`, 25_000_000: system clock frequency.
- `BAUD`, 9600: line rate.
- `OVS`, 16: oversampling ticks per bit.
- `DEPTH`, 4: FIFO entries; must be a power of two, at least 2.

Ports:
- `clk`, in, 1: system clock, rising edge.
- `clr`, in, 1: reset, asynchronous, active-low.
- `mRxD`, in, 1: raw UART line, asynchronous, idles high.
- `rd_en`, in, 1: pop the FIFO head this cycle.
- `rx_data`, out, 8: FIFO head byte; 0x00 when empty.
- `rx_valid`, out, 1: FIFO non-empty.
- `note_code`, out, 3: decode of `rx_data`.
  - 'C','D','E','F','G','A','B' give 1 to 7; lowercase letters decode the same.
  - Any other byte, or an empty FIFO, gives 0.
- `frame_err`, out, 1: one-cycle pulse when a frame is rejected because its stop bit sampled 0.
- `overrun`, out, 1: one-cycle pulse when a valid byte is dropped because the FIFO is full.

## Operation
- Input sync: two flops on `mRxD`, both reset to 1. All logic uses only the synced value `rxs`.
- Tick generator:
  - `DIV = round(CLK_HZ/(BAUD*OVS))`, which is 163 at the defaults.
  - Free-running counter; a one-cycle `tick` every DIV clocks.
  - The counter restarts at 0 on start-edge detection.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: a falling edge of `rxs` moves to START and clears the tick count.
  - START: at tick 7, i.e. mid-bit on the 8th tick, sample `rxs`.
    - 1: false start; return to IDLE with no outputs.
    - 0: go to DATA with tick count 0 and bit index 0.
  - DATA: every 16 ticks, sample `rxs` into the shift register, LSB first. After bit 7, go to STOP.
  - STOP: at the 16th tick, sample `rxs`.
    - 1: push the byte and go to IDLE.
    - 0: pulse `frame_err`, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: go to IDLE once `rxs` = 1.
- FIFO: DEPTH entries, FWFT, pointers one bit wider than the address.
  - Push on a valid stop. Pop on `rd_en && rx_valid`.
  - `rd_en` while empty is ignored.
  - Push while full without a pop: the byte is dropped and `overrun` pulses. Contents are unchanged.
  - Push and pop in the same cycle while full: both take effect, no overrun, count unchanged.
  - Push and pop in the same cycle while count is 1: the new byte becomes the head.
- Reset value of every output is 0. FSM to IDLE, FIFO empty, sync flops at 1.
- Reset in the middle of a frame abandons it. After release, a byte is only received from a fresh falling edge.

## Timing
- Bit period: 16·DIV = 2608 clocks at the defaults.
- Stop-bit sample to `rx_valid` high: 1 clock, since the push is registered.
- `rx_valid` and `rx_data` update on the clock after a pop.
- `note_code` is combinational from the FIFO head, with zero added latency.
- `mRxD` to `rxs`: 2 clocks of synchroniser delay.
- The receiver is in IDLE half a bit before the nominal end of the stop bit. It tolerates back-to-back frames and ±2% baud mismatch.

## Structure
- `note_pkg` holds:
  - the FSM state enum;
  - the note-code constants, NOTE_NONE = 0 and NOTE_C..NOTE_B = 1..7;
  - the ASCII-to-note decode function, shared with the sequencer and display decoder.
- Sub-module `rx_fifo` (DEPTH, 8-bit, FWFT, full/empty flags). The tick generator and FSM stay in the top module.

## Test plan
- Send 0x41 ('A') at 9600 baud → `rx_valid`=1 one clock after the stop sample, `rx_data`=0x41, `note_code`=6. Pulse `rd_en` → `rx_valid`=0, `note_code`=0.
- Drive `mRxD` low for 3 ticks (489 clocks), then high → no push, no `frame_err`, FSM back in IDLE.
- Send 0x63 ('c') with the stop bit forced to 0 and the line held low for 2 bit times → `frame_err` pulses once, FIFO empty. A following clean 0x44 is received with `note_code`=2.
- Send 0x43, 0x44, 0x45, 0x46, 0x47 back-to-back without reading → `overrun` pulses once on the 5th byte. Four pops return 0x43..0x46 in order.
- FIFO full; assert `rd_en` in the cycle the next stop bit pushes 0x42 → no overrun, count stays 4, 0x42 is last out.
- Assert `clr`=0 during data bit 3 → all outputs 0 immediately. Release, then send 0x45 → `rx_data`=0x45, `note_code`=3, no `frame_err`.
